// File: rtl/shift_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : shift_sequencer_if
// Description : Start/ready request and valid/ack result bundle for the shifter.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface shift_sequencer_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) ();
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] shamt;
    logic               in_ready;
    logic               busy;
    logic [WIDTH-1:0]   result;
    logic               result_valid;
    logic               result_ack;

    modport master (
        output start, op, operand, shamt, result_ack,
        input  in_ready, busy, result, result_valid
    );

    modport slave (
        input  start, op, operand, shamt, result_ack,
        output in_ready, busy, result, result_valid
    );
endinterface

`default_nettype wire

// File: rtl/shift_sequencer.sv
//------------------------------------------------------------------------------
// Module      : shift_sequencer
// Description : Multi-cycle SLL/SRA/SRL/ROR using one shared power-of-two stage.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    shift_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [SHAMT_W-1:0] hi_bit;
    logic [SHAMT_W-1:0] rot_l;
    logic [SHAMT_W-1:0] rem_next;
    logic [WIDTH-1:0]   stage;

    // hi_bit is the one-hot highest set bit of rem, which doubles as the stage amount.
    always_comb begin
        hi_bit = '0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (rem_q[i]) begin
                hi_bit    = '0;
                hi_bit[i] = 1'b1;
            end
        end
        rot_l    = -hi_bit;
        rem_next = rem_q & ~hi_bit;
        case (op_q)
            OP_SLL:  stage = acc_q << hi_bit;
            OP_SRA:  stage = $unsigned($signed(acc_q) >>> hi_bit);
            OP_SRL:  stage = acc_q >> hi_bit;
            OP_ROR:  stage = (acc_q >> hi_bit) | (acc_q << rot_l);
            default: stage = acc_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d = bus.operand;
                    rem_d = bus.shamt;
                    op_d  = bus.op;
                    if (bus.shamt == '0) begin
                        state_d  = S_DONE;
                        result_d = bus.operand;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = stage;
                rem_d = rem_next;
                if (rem_next == '0) begin
                    state_d  = S_DONE;
                    result_d = stage;
                end
            end
            S_DONE: begin
                if (bus.result_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.busy         = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.result       = result_q;

endmodule

`default_nettype wire
